wb_arbiter: RTL and testbench

- Owns the single regfile write port and shares it between two write-back requesters: the single-cycle ALU path and the long-latency LSU/muldiv path.
- Keeps a per-register busy scoreboard for outstanding long-latency destinations and stalls issue on RAW/WAW hazards against them.
- Sits between the execute/memory stages and the regfile write port (we, rd_addr, w_data).

---
 rtl/wb_arbiter_pkg.sv | 6 +
 rtl/wb_arbiter_if.sv | 30 +++
 rtl/wb_scoreboard.sv | 32 +++
 rtl/wb_arbiter.sv | 50 +++++
 tb/tb_wb_arbiter.sv | 122 ++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths and grant source enum for the write-back arbiter
package wb_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;
  typedef enum logic {GRANT_ALU, GRANT_LSU} grant_src_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: requester, issue and regfile write-port signals of the write-back arbiter
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN = wb_arbiter_pkg::XLEN,
  parameter int AW = REG_ADDR_W
);
  logic alu_valid, alu_ready;
  logic [AW-1:0] alu_rd;
  logic [XLEN-1:0] alu_data;
  logic lsu_valid, lsu_ready;
  logic [AW-1:0] lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic iss_valid, iss_long, iss_stall;
  logic [AW-1:0] iss_rd, iss_rs1, iss_rs2;
  logic rf_we;
  logic [AW-1:0] rf_rd_addr;
  logic [XLEN-1:0] rf_w_data;
  logic sb_err;
  modport slave (
    input alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input iss_valid, iss_long, iss_rd, iss_rs1, iss_rs2,
    output alu_ready, lsu_ready, iss_stall, rf_we, rf_rd_addr, rf_w_data, sb_err
  );
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_long, iss_rd, iss_rs1, iss_rs2,
    input alu_ready, lsu_ready, iss_stall, rf_we, rf_rd_addr, rf_w_data, sb_err
  );
endinterface

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: busy bits for outstanding long-latency destinations, hazard stall and sticky error
module wb_scoreboard
  import wb_arbiter_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iss_valid,
  input  logic                  iss_long,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  input  logic [REG_ADDR_W-1:0] iss_rs1,
  input  logic [REG_ADDR_W-1:0] iss_rs2,
  input  logic                  lsu_xfer,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  output logic                  iss_stall,
  output logic                  sb_err
);
  logic [NREG-1:0] busy, set_v, clr_v;
  assign iss_stall = iss_valid && (busy[iss_rs1] || busy[iss_rs2] || busy[iss_rd]);
  assign set_v = (iss_valid && iss_long && !iss_stall && iss_rd != '0) ? NREG'(1) << iss_rd : '0;
  assign clr_v = lsu_xfer ? NREG'(1) << lsu_rd : '0;
  // set on long issue, clear on LSU write-back; x0 never busy; flag writes to non-busy regs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      busy <= '0;
      sb_err <= 1'b0;
    end else begin
      busy <= ((busy & ~clr_v) | set_v) & ~NREG'(1);
      sb_err <= sb_err || (lsu_xfer && lsu_rd != '0 && !busy[lsu_rd]);
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin sharing of the regfile write port between ALU and LSU write-back
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN = wb_arbiter_pkg::XLEN,
  parameter int NREG = 32
) (
  input logic         clk,
  input logic         reset,
  wb_arbiter_if.slave bus
);
  grant_src_t last_grant;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [XLEN-1:0] w_data;
  assign bus.alu_ready = reset && bus.alu_valid && (!bus.lsu_valid || last_grant == GRANT_LSU);
  assign bus.lsu_ready = reset && bus.lsu_valid && !bus.alu_ready;
  assign w_rd = bus.alu_ready ? bus.alu_rd : bus.lsu_rd;
  assign w_data = bus.alu_ready ? bus.alu_data : bus.lsu_data;
  // remember the last winner so ties alternate
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_grant <= GRANT_LSU;
    else if (bus.alu_ready) last_grant <= GRANT_ALU;
    else if (bus.lsu_ready) last_grant <= GRANT_LSU;
  // register the granted write one cycle after the handshake; x0 writes are swallowed
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.rf_we <= 1'b0;
      bus.rf_rd_addr <= '0;
      bus.rf_w_data <= '0;
    end else begin
      bus.rf_we <= (bus.alu_ready || bus.lsu_ready) && w_rd != '0;
      if ((bus.alu_ready || bus.lsu_ready) && w_rd != '0) begin
        bus.rf_rd_addr <= w_rd;
        bus.rf_w_data <= w_data;
      end
    end
  wb_scoreboard #(.NREG(NREG)) u_sb (
    .clk(clk),
    .reset(reset),
    .iss_valid(bus.iss_valid),
    .iss_long(bus.iss_long),
    .iss_rd(bus.iss_rd),
    .iss_rs1(bus.iss_rs1),
    .iss_rs2(bus.iss_rs2),
    .lsu_xfer(bus.lsu_ready),
    .lsu_rd(bus.lsu_rd),
    .iss_stall(bus.iss_stall),
    .sb_err(bus.sb_err)
  );
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed checks of arbitration, write stage, scoreboard and async reset
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  wb_arbiter_if #(.XLEN(32)) bus ();
  wb_arbiter #(.XLEN(32), .NREG(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic idle();
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    bus.iss_valid = 0; bus.iss_long = 0; bus.iss_rd = 0; bus.iss_rs1 = 0; bus.iss_rs2 = 0;
  endtask

  task automatic issue(input logic lng, input logic [4:0] rd, input logic [4:0] rs1);
    bus.iss_valid = 1; bus.iss_long = lng; bus.iss_rd = rd; bus.iss_rs1 = rs1; bus.iss_rs2 = 0;
  endtask

  task automatic test_reset();
    idle();
    bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'h55;
    repeat (2) begin
      @(negedge clk); #1;
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", bus.rf_we); end
      checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b exp 0", bus.alu_ready); end
    end
    checks++; if (bus.rf_rd_addr !== 5'd0 || bus.rf_w_data !== 32'd0) begin errors++; $display("FAIL reset_addr_data got %0d/%0h exp 0/0", bus.rf_rd_addr, bus.rf_w_data); end
    checks++; if (bus.sb_err !== 1'b0 || bus.iss_stall !== 1'b0) begin errors++; $display("FAIL reset_err_stall got %0b/%0b exp 0/0", bus.sb_err, bus.iss_stall); end
    reset = 1; #1;
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %0b exp 1", bus.alu_ready); end
    @(negedge clk); bus.alu_valid = 0;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd_addr !== 5'd5 || bus.rf_w_data !== 32'h55) begin errors++; $display("FAIL release_write got %0b/%0d/%0h exp 1/5/55", bus.rf_we, bus.rf_rd_addr, bus.rf_w_data); end
  endtask

  task automatic test_rd0();
    @(negedge clk);
    bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 32'hDEADBEEF; #1;
    checks++; if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL rd0_ready got %0b/%0b exp 1/0", bus.alu_ready, bus.lsu_ready); end
    @(negedge clk); bus.alu_valid = 0;
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL rd0_we got %0b exp 0", bus.rf_we); end
  endtask

  task automatic test_raw();
    @(negedge clk); issue(1, 10, 0); #1;
    checks++; if (bus.iss_stall !== 1'b0) begin errors++; $display("FAIL raw_first got %0b exp 0", bus.iss_stall); end
    @(negedge clk); issue(0, 11, 10); #1;
    checks++; if (bus.iss_stall !== 1'b1) begin errors++; $display("FAIL raw_stall got %0b exp 1", bus.iss_stall); end
    @(negedge clk); bus.lsu_valid = 1; bus.lsu_rd = 10; bus.lsu_data = 32'h1010; #1;
    checks++; if (bus.lsu_ready !== 1'b1 || bus.iss_stall !== 1'b1) begin errors++; $display("FAIL raw_clear_cycle got %0b/%0b exp 1/1", bus.lsu_ready, bus.iss_stall); end
    @(negedge clk); bus.lsu_valid = 0; #1;
    checks++; if (bus.iss_stall !== 1'b0) begin errors++; $display("FAIL raw_release got %0b exp 0", bus.iss_stall); end
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd_addr !== 5'd10 || bus.rf_w_data !== 32'h1010) begin errors++; $display("FAIL raw_write got %0b/%0d/%0h exp 1/10/1010", bus.rf_we, bus.rf_rd_addr, bus.rf_w_data); end
    bus.iss_valid = 0;
  endtask

  task automatic test_waw_x0();
    @(negedge clk); issue(1, 0, 0); #1;
    checks++; if (bus.iss_stall !== 1'b0) begin errors++; $display("FAIL x0_issue got %0b exp 0", bus.iss_stall); end
    @(negedge clk); issue(1, 4, 0); #1;
    checks++; if (bus.iss_stall !== 1'b0) begin errors++; $display("FAIL x0_not_busy got %0b exp 0", bus.iss_stall); end
    @(negedge clk); #1;
    checks++; if (bus.iss_stall !== 1'b1) begin errors++; $display("FAIL waw_stall got %0b exp 1", bus.iss_stall); end
    @(negedge clk); bus.lsu_valid = 1; bus.lsu_rd = 4; bus.lsu_data = 32'h44; #1;
    checks++; if (bus.iss_stall !== 1'b1) begin errors++; $display("FAIL waw_clear_cycle got %0b exp 1", bus.iss_stall); end
    @(negedge clk); bus.lsu_valid = 0; #1;
    checks++; if (bus.iss_stall !== 1'b0) begin errors++; $display("FAIL waw_release got %0b exp 0", bus.iss_stall); end
    @(negedge clk); bus.iss_valid = 0; bus.lsu_valid = 1; bus.lsu_rd = 4; #1;
    checks++; if (bus.iss_stall !== 1'b0) begin errors++; $display("FAIL stall_no_valid got %0b exp 0", bus.iss_stall); end
    @(negedge clk); bus.lsu_valid = 0;
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL waw_err got %0b exp 0", bus.sb_err); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_alu;
    exp_alu = 4'b0101;
    @(negedge clk); issue(1, 7, 0);
    @(negedge clk); bus.iss_valid = 0;
    bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_data = 32'hA3;
    bus.lsu_valid = 1; bus.lsu_rd = 7; bus.lsu_data = 32'hB7;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) issue(1, 7, 0);
      if (k == 3) bus.iss_valid = 0;
      #1;
      checks++; if (bus.alu_ready !== exp_alu[k] || bus.lsu_ready !== !exp_alu[k]) begin errors++; $display("FAIL rr_grant%0d got %0b/%0b exp %0b/%0b", k, bus.alu_ready, bus.lsu_ready, exp_alu[k], !exp_alu[k]); end
      if (k > 0) begin
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd_addr !== (exp_alu[k-1] ? 5'd3 : 5'd7)) begin errors++; $display("FAIL rr_addr%0d got %0b/%0d exp 1/%0d", k, bus.rf_we, bus.rf_rd_addr, exp_alu[k-1] ? 3 : 7); end
      end
      @(negedge clk);
    end
    bus.alu_valid = 0; bus.lsu_valid = 0;
    checks++; if (bus.rf_rd_addr !== 5'd7 || bus.rf_w_data !== 32'hB7) begin errors++; $display("FAIL rr_last got %0d/%0h exp 7/b7", bus.rf_rd_addr, bus.rf_w_data); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL rr_err got %0b exp 0", bus.sb_err); end
  endtask

  task automatic test_err_async_reset();
    @(negedge clk); bus.lsu_valid = 1; bus.lsu_rd = 9; bus.lsu_data = 32'h99; issue(1, 12, 0);
    @(negedge clk); bus.lsu_valid = 0; issue(0, 13, 12);
    bus.alu_valid = 1; bus.alu_rd = 6; bus.alu_data = 32'h66; #1;
    checks++; if (bus.sb_err !== 1'b1 || bus.rf_we !== 1'b1 || bus.rf_rd_addr !== 5'd9) begin errors++; $display("FAIL err_set got %0b/%0b/%0d exp 1/1/9", bus.sb_err, bus.rf_we, bus.rf_rd_addr); end
    checks++; if (bus.iss_stall !== 1'b1) begin errors++; $display("FAIL err_busy12 got %0b exp 1", bus.iss_stall); end
    @(negedge clk); bus.alu_valid = 0; #1;
    checks++; if (bus.sb_err !== 1'b1 || bus.rf_we !== 1'b1 || bus.rf_rd_addr !== 5'd6) begin errors++; $display("FAIL err_sticky got %0b/%0b/%0d exp 1/1/6", bus.sb_err, bus.rf_we, bus.rf_rd_addr); end
    #1 reset = 0; #1;
    checks++; if (bus.sb_err !== 1'b0 || bus.rf_we !== 1'b0 || bus.iss_stall !== 1'b0 || bus.rf_rd_addr !== 5'd0) begin errors++; $display("FAIL async_reset got %0b/%0b/%0b/%0d exp 0/0/0/0", bus.sb_err, bus.rf_we, bus.iss_stall, bus.rf_rd_addr); end
    @(negedge clk); reset = 1; #1;
    checks++; if (bus.iss_stall !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %0b exp 0", bus.iss_stall); end
    bus.iss_valid = 0;
  endtask

  initial begin
    test_reset();
    test_rd0();
    test_raw();
    test_waw_x0();
    test_round_robin();
    test_err_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
